// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes and sequencer state encoding shared by the sequencer, ALU and decoder.
// Optional single-step support (state S_PAUSE) is enabled by CPU_SEQ_SINGLE_STEP_EN.
package cpu_pkg;
    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_SKZ = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_LDA = 3'd5;
    localparam logic [2:0] OP_STO = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;
    typedef enum logic [2:0] {
        S_RST  = 3'd0,
        S_FOP  = 3'd1,
        S_FARG = 3'd2,
        S_EXEC = 3'd3,
        S_SKIP = 3'd4,
`ifdef CPU_SEQ_SINGLE_STEP_EN
        S_PAUSE = 3'd6,
`endif
        S_HALT = 3'd5
    } state_t;
    // Opcodes whose execute phase reads the operand address and loads the accumulator.
    function automatic logic is_acc_op(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
    endfunction
endpackage

// File: rtl/cpu_seq_ctrl_if.sv
// cpu_seq_ctrl_if: decode inputs and control strobes between the sequencer and the datapath.
// Carries the step input only when CPU_SEQ_SINGLE_STEP_EN is defined.
interface cpu_seq_ctrl_if;
    logic [2:0] opcode;
    logic       acc_zero;
    logic       mem_ready;
`ifdef CPU_SEQ_SINGLE_STEP_EN
    logic       step;
`endif
    logic       mem_rd;
    logic       mem_wr;
    logic       addr_sel;
    logic       ir_op_ld;
    logic       ir_arg_ld;
    logic       pc_en;
    logic       pc_chg_en;
    logic       acc_ld;
    logic       instr_done;
    logic       halted;
    modport master (
`ifdef CPU_SEQ_SINGLE_STEP_EN
        input  step,
`endif
        input  opcode, acc_zero, mem_ready,
        output mem_rd, mem_wr, addr_sel, ir_op_ld, ir_arg_ld,
        output pc_en, pc_chg_en, acc_ld, instr_done, halted
    );
    modport slave (
`ifdef CPU_SEQ_SINGLE_STEP_EN
        output step,
`endif
        output opcode, acc_zero, mem_ready,
        input  mem_rd, mem_wr, addr_sel, ir_op_ld, ir_arg_ld,
        input  pc_en, pc_chg_en, acc_ld, instr_done, halted
    );
endinterface

// File: rtl/cpu_seq_ctrl.sv
// cpu_seq_ctrl: fetch/execute sequencer of the 8-bit RISC CPU.
// Define CPU_SEQ_SINGLE_STEP_EN to pause before every opcode fetch until step is high.
module cpu_seq_ctrl
    import cpu_pkg::*;
#(
    parameter int RST_HOLD = 2
) (
    input logic            clock,
    input logic            rst,
    cpu_seq_ctrl_if.master bus
);
    localparam logic [3:0] HOLD_LAST = 4'(RST_HOLD - 1);
`ifdef CPU_SEQ_SINGLE_STEP_EN
    localparam state_t S_NEXT = S_PAUSE;
`else
    localparam state_t S_NEXT = S_FOP;
`endif
    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic mem_rd, mem_wr, addr_sel, ir_op_ld, ir_arg_ld;
    logic pc_en, pc_chg_en, acc_ld, instr_done, halted;
    logic rdy;
    assign rdy = bus.mem_ready;
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q <= S_RST;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        addr_sel   = 1'b0;
        ir_op_ld   = 1'b0;
        ir_arg_ld  = 1'b0;
        pc_en      = 1'b0;
        pc_chg_en  = 1'b0;
        acc_ld     = 1'b0;
        instr_done = 1'b0;
        halted     = 1'b0;
        case (state_q)
            S_RST: begin
                cnt_d   = cnt_q + 4'd1;
                state_d = (cnt_q == HOLD_LAST) ? S_NEXT : S_RST;
            end
            S_FOP: begin
                mem_rd   = 1'b1;
                ir_op_ld = rdy;
                pc_en    = rdy;
                state_d  = rdy ? S_FARG : S_FOP;
            end
            S_FARG: begin
                mem_rd    = 1'b1;
                ir_arg_ld = rdy;
                pc_en     = rdy;
                state_d   = rdy ? S_EXEC : S_FARG;
            end
            S_EXEC: begin
                case (bus.opcode)
                    OP_HLT: begin
                        instr_done = 1'b1;
                        state_d    = S_HALT;
                    end
                    OP_SKZ: begin
                        pc_en      = bus.acc_zero;
                        instr_done = !bus.acc_zero;
                        state_d    = bus.acc_zero ? S_SKIP : S_NEXT;
                    end
                    OP_STO: begin
                        mem_wr     = 1'b1;
                        addr_sel   = 1'b1;
                        instr_done = rdy;
                        state_d    = rdy ? S_NEXT : S_EXEC;
                    end
                    OP_JMP: begin
                        pc_en      = 1'b1;
                        pc_chg_en  = 1'b1;
                        instr_done = 1'b1;
                        state_d    = S_NEXT;
                    end
                    default: begin
                        mem_rd     = is_acc_op(bus.opcode);
                        addr_sel   = 1'b1;
                        acc_ld     = rdy;
                        instr_done = rdy;
                        state_d    = rdy ? S_NEXT : S_EXEC;
                    end
                endcase
            end
            // Second PC increment steps over the 2-byte instruction being skipped.
            S_SKIP: begin
                pc_en      = 1'b1;
                instr_done = 1'b1;
                state_d    = S_NEXT;
            end
            S_HALT: halted = 1'b1;
`ifdef CPU_SEQ_SINGLE_STEP_EN
            S_PAUSE: state_d = bus.step ? S_FOP : S_PAUSE;
`endif
            default: state_d = S_RST;
        endcase
    end
    assign bus.mem_rd     = mem_rd;
    assign bus.mem_wr     = mem_wr;
    assign bus.addr_sel   = addr_sel;
    assign bus.ir_op_ld   = ir_op_ld;
    assign bus.ir_arg_ld  = ir_arg_ld;
    assign bus.pc_en      = pc_en;
    assign bus.pc_chg_en  = pc_chg_en;
    assign bus.acc_ld     = acc_ld;
    assign bus.instr_done = instr_done;
    assign bus.halted     = halted;
endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// tb_cpu_seq_ctrl: directed vector table plus randomized instruction traces for cpu_seq_ctrl.
module tb_cpu_seq_ctrl;
    import cpu_pkg::*;
    localparam int HOLD = 2;
    localparam logic [9:0] RD = 10'h200, WR = 10'h100, AS = 10'h080, OPL = 10'h040, ARL = 10'h020;
    localparam logic [9:0] PE = 10'h010, PC = 10'h008, AL = 10'h004, DN = 10'h002, HL = 10'h001;
    localparam logic [9:0] Z = 10'h000;
    typedef struct {
        logic       rdy;
        logic       az;
        logic [2:0] op;
        logic [9:0] exp;
        string      nm;
    } vec_t;
    logic clock = 1'b0;
    logic rst   = 1'b1;
    int   errs  = 0;
    int   nchk  = 0;
    vec_t q[$];
    vec_t tbl[$];
    cpu_seq_ctrl_if bus();
    cpu_seq_ctrl #(.RST_HOLD(HOLD)) dut (.clock(clock), .rst(rst), .bus(bus));
    always #5 clock = ~clock;
    function automatic logic [9:0] outs();
        return {bus.mem_rd, bus.mem_wr, bus.addr_sel, bus.ir_op_ld, bus.ir_arg_ld,
                bus.pc_en, bus.pc_chg_en, bus.acc_ld, bus.instr_done, bus.halted};
    endfunction
    task automatic check(input string nm, input logic [9:0] act, input logic [9:0] exp);
        nchk++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %03h want %03h at %0t", nm, act, exp, $time);
        end
    endtask
    function automatic vec_t mk(input logic rdy, input logic az, input logic [2:0] op,
                                input logic [9:0] e, input string nm);
        return '{rdy: rdy, az: az, op: op, exp: e, nm: nm};
    endfunction
    function automatic void put(input logic rdy, input logic az, input logic [2:0] op,
                                input logic [9:0] e, input string nm);
        q.push_back(mk(rdy, az, op, e, nm));
    endfunction
    // Expected trace of one instruction: fetch two bytes, then the opcode's execute rule.
    function automatic void instr(input logic [2:0] op, input logic az, input int w1,
                                  input int w2, input int w3);
        for (int i = 0; i < w1; i++) put(1'b0, 1'($urandom), op, RD, "fop_wait");
        put(1'b1, 1'($urandom), op, RD | OPL | PE, "fop");
        for (int i = 0; i < w2; i++) put(1'b0, 1'($urandom), op, RD, "farg_wait");
        put(1'b1, 1'($urandom), op, RD | ARL | PE, "farg");
        if (op == OP_HLT) put(1'($urandom), 1'($urandom), op, DN, "hlt");
        else if (op == OP_JMP) put(1'($urandom), 1'($urandom), op, PE | PC | DN, "jmp");
        else if (op == OP_SKZ) begin
            put(1'($urandom), az, op, az ? PE : DN, "skz");
            if (az) put(1'($urandom), 1'($urandom), op, PE | DN, "skip");
        end else begin
            logic [9:0] s;
            s = (op == OP_STO) ? (WR | AS) : (RD | AS);
            for (int i = 0; i < w3; i++) put(1'b0, 1'($urandom), op, s, "mem_wait");
            put(1'b1, 1'($urandom), op, s | DN | ((op == OP_STO) ? Z : AL), "mem_done");
        end
    endfunction
    function automatic void hold_rows();
        for (int i = 0; i < HOLD; i++) put(1'($urandom), 1'($urandom), 3'($urandom), Z, "rst_hold");
    endfunction
    task automatic apply(input vec_t v);
        bus.mem_ready = v.rdy;
        bus.acc_zero  = v.az;
        bus.opcode    = v.op;
        @(negedge clock);
        check(v.nm, outs(), v.exp);
        @(posedge clock);
        #1;
    endtask
    task automatic run_q();
        while (q.size() > 0) apply(q.pop_front());
    endtask
    initial begin
        tbl.push_back(mk(1, 0, OP_JMP, Z, "hold0"));
        tbl.push_back(mk(1, 0, OP_JMP, Z, "hold1"));
        tbl.push_back(mk(1, 0, OP_JMP, RD | OPL | PE, "jmp_fop"));
        tbl.push_back(mk(1, 0, OP_JMP, RD | ARL | PE, "jmp_farg"));
        tbl.push_back(mk(1, 0, OP_JMP, PE | PC | DN, "jmp_exec"));
        tbl.push_back(mk(1, 1, OP_SKZ, RD | OPL | PE, "skz1_fop"));
        tbl.push_back(mk(1, 1, OP_SKZ, RD | ARL | PE, "skz1_farg"));
        tbl.push_back(mk(1, 1, OP_SKZ, PE, "skz1_exec"));
        tbl.push_back(mk(1, 0, OP_SKZ, PE | DN, "skz1_skip"));
        tbl.push_back(mk(1, 0, OP_SKZ, RD | OPL | PE, "skz0_fop"));
        tbl.push_back(mk(1, 0, OP_SKZ, RD | ARL | PE, "skz0_farg"));
        tbl.push_back(mk(1, 0, OP_SKZ, DN, "skz0_exec"));
        tbl.push_back(mk(0, 0, OP_ADD, RD, "fop_wait"));
        tbl.push_back(mk(1, 0, OP_ADD, RD | OPL | PE, "add_fop"));
        bus.mem_ready = 1'b0;
        bus.acc_zero  = 1'b0;
        bus.opcode    = OP_HLT;
        #1 check("in_reset", outs(), Z);
        @(posedge clock);
        #1 rst = 1'b0;
        foreach (tbl[i]) apply(tbl[i]);
        put(1, 0, OP_ADD, RD | ARL | PE, "add_farg");
        put(0, 1, OP_ADD, RD | AS, "add_wait");
        put(1, 0, OP_ADD, RD | AS | AL | DN, "add_done");
        instr(OP_LDA, 1'b0, 0, 0, 5);
        instr(OP_STO, 1'b0, 1, 0, 3);
        instr(OP_HLT, 1'b0, 0, 0, 0);
        for (int i = 0; i < 5; i++) put(1'($urandom), 1'($urandom), 3'($urandom), HL, "halt_hold");
        run_q();
        rst = 1'b1;
        #1 check("rst_from_halt", outs(), Z);
        @(posedge clock);
        #1 rst = 1'b0;
        hold_rows();
        instr(OP_JMP, 1'b0, 1, 1, 0);
        put(1, 0, OP_LDA, RD | OPL | PE, "fop");
        put(0, 0, OP_LDA, RD, "farg_wait");
        put(0, 0, OP_LDA, RD, "farg_wait");
        run_q();
        #2 rst = 1'b1;
        #1 check("async_rst_farg", outs(), Z);
        @(posedge clock);
        #1 rst = 1'b0;
        hold_rows();
        for (int n = 0; n < 60; n++)
            instr(3'($urandom_range(7, 1)), 1'($urandom), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 3));
        instr(OP_HLT, 1'b0, 0, 0, 0);
        put(1, 1, OP_STO, HL, "final_halt");
        run_q();
        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end
endmodule
